// File: rtl/core_pkg.sv
// Shared core constants and the reservation-station entry layout.
// Widths here set the defaults of the ALU reservation station parameters.
package core_pkg;

    localparam int FETCH_WIDTH = 2;
    localparam int LOG2_PREGS  = 6;
    localparam int XLEN        = 64;
    localparam int RS_ENTRIES  = 16;
    localparam int ISSUE_WIDTH = 2;

    typedef struct packed {
        logic                  valid;
        logic [7:0]            op;
        logic [LOG2_PREGS-1:0] dst;
        logic [LOG2_PREGS-1:0] src1_tag;
        logic [LOG2_PREGS-1:0] src2_tag;
        logic                  src1_rdy;
        logic                  src2_rdy;
        logic [63:0]           src1_val;
        logic [63:0]           src2_val;
        logic [5:0]            rob_tag;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first picker: each grant takes the oldest eligible entry not already
// granted by a lower-numbered port. age[j][i]=1 means entry j is older than i.
module rs_age_select
    import core_pkg::*;
#(
    parameter int N      = RS_ENTRIES,
    parameter int GRANTS = ISSUE_WIDTH
) (
    input  logic [N-1:0]                eligible,
    input  logic [N-1:0][N-1:0]         age,
    output logic [GRANTS-1:0][N-1:0]    grant
);

    logic [N-1:0] remaining;
    logic         older;

    always_comb begin
        remaining = eligible;
        grant     = '0;
        older     = 1'b0;
        for (int k = 0; k < GRANTS; k++) begin
            for (int i = 0; i < N; i++) begin
                older = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (remaining[j] && age[j][i]) older = 1'b1;
                end
                if (remaining[i] && !older) grant[k][i] = 1'b1;
            end
            remaining = remaining & ~grant[k];
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Unified ALU/branch reservation station: allocates renamed ops, wakes them from
// the 2-wide CDB, and issues the oldest ready ops over a valid/ready handshake.
module alu_reservation_station
    import core_pkg::*;
#(
    parameter int FETCH_W    = core_pkg::FETCH_WIDTH,
    parameter int ISSUE_W    = core_pkg::ISSUE_WIDTH,
    parameter int RS_ENTRIES = core_pkg::RS_ENTRIES,
    parameter int PHYS_W     = core_pkg::LOG2_PREGS,
    parameter int XLEN       = core_pkg::XLEN
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_pipeline,
    input  logic [FETCH_W-1:0]                rs_alloc_en,
    input  logic [FETCH_W-1:0][PHYS_W-1:0]    rs_alloc_dst_tag,
    input  logic [FETCH_W-1:0][PHYS_W-1:0]    rs_alloc_src1_tag,
    input  logic [FETCH_W-1:0][PHYS_W-1:0]    rs_alloc_src2_tag,
    input  logic [FETCH_W-1:0][63:0]          rs_alloc_src1_val,
    input  logic [FETCH_W-1:0][63:0]          rs_alloc_src2_val,
    input  logic [FETCH_W-1:0]                rs_alloc_src1_ready,
    input  logic [FETCH_W-1:0]                rs_alloc_src2_ready,
    input  logic [FETCH_W-1:0][7:0]           rs_alloc_op,
    input  logic [FETCH_W-1:0][5:0]           rs_alloc_rob_tag,
    output logic                              rs_full,
    output logic [$clog2(RS_ENTRIES):0]       rs_count,
    input  logic [1:0]                        cdb_valid,
    input  logic [1:0][PHYS_W-1:0]            cdb_tag,
    input  logic [1:0][XLEN-1:0]              cdb_value,
    output logic [ISSUE_W-1:0]                issue_valid,
    input  logic [ISSUE_W-1:0]                issue_ready,
    output logic [ISSUE_W-1:0][7:0]           issue_op,
    output logic [ISSUE_W-1:0][PHYS_W-1:0]    issue_dst_tag,
    output logic [ISSUE_W-1:0][63:0]          issue_src1_val,
    output logic [ISSUE_W-1:0][63:0]          issue_src2_val,
    output logic [ISSUE_W-1:0][5:0]           issue_rob_tag
);

    localparam int CW = $clog2(RS_ENTRIES) + 1;
    localparam int IW = $clog2(RS_ENTRIES);

    rs_entry_t                               entries      [RS_ENTRIES];
    rs_entry_t                               entries_next [RS_ENTRIES];
    rs_entry_t                               new_ent;
    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0]   age, age_next;
    logic [CW-1:0]                           count_q, count_next;
    logic                                    full_q, full_next;
    logic [RS_ENTRIES-1:0]                   valid_vec, eligible, freed, taken;
    logic [ISSUE_W-1:0][RS_ENTRIES-1:0]      grant;
    logic [FETCH_W-1:0]                      lane_go;
    logic [FETCH_W-1:0][IW-1:0]              lane_slot;
    logic                                    alloc_ok;

    assign rs_full  = full_q;
    assign rs_count = count_q;
    // Allocation is refused while full (checked below) and during a flush.
    assign alloc_ok = !full_q && !flush_pipeline;

    always_comb begin
        valid_vec = '0;
        eligible  = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
            eligible[i]  = entries[i].valid && entries[i].src1_rdy && entries[i].src2_rdy;
        end
    end

    rs_age_select #(.N(RS_ENTRIES), .GRANTS(ISSUE_W)) u_age_select (
        .eligible (eligible),
        .age      (age),
        .grant    (grant)
    );

    // Handshake: issue_valid[k] marks a held op on port k; the entry leaves the
    // station only at a rising edge where issue_valid[k] and issue_ready[k] are
    // both 1. Without acceptance the pick is recomputed next cycle.
    always_comb begin
        issue_valid    = '0;
        issue_op       = '0;
        issue_dst_tag  = '0;
        issue_src1_val = '0;
        issue_src2_val = '0;
        issue_rob_tag  = '0;
        freed          = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (!flush_pipeline && (|grant[k])) begin
                issue_valid[k] = 1'b1;
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (grant[k][i]) begin
                        issue_op[k]       = entries[i].op;
                        issue_dst_tag[k]  = entries[i].dst;
                        issue_src1_val[k] = entries[i].src1_val;
                        issue_src2_val[k] = entries[i].src2_val;
                        issue_rob_tag[k]  = entries[i].rob_tag;
                    end
                end
                if (issue_ready[k]) freed = freed | grant[k];
            end
        end
    end

    // Slots are chosen from registered occupancy, so a slot freed this cycle waits.
    always_comb begin
        taken     = '0;
        lane_go   = '0;
        lane_slot = '0;
        for (int l = 0; l < FETCH_W; l++) begin
            if (rs_alloc_en[l] && alloc_ok) begin
                for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
                    if (!valid_vec[i] && !taken[i]) begin
                        lane_go[l]   = 1'b1;
                        lane_slot[l] = IW'(i);
                    end
                end
                if (lane_go[l]) taken[lane_slot[l]] = 1'b1;
            end
        end
    end

    always_comb begin
        entries_next = entries;
        age_next     = age;
        new_ent      = '0;
        // CDB lane 1 is applied last so it wins when both lanes match.
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (entries[i].valid && cdb_valid[c]) begin
                    if (!entries[i].src1_rdy && entries[i].src1_tag == cdb_tag[c]) begin
                        entries_next[i].src1_rdy = 1'b1;
                        entries_next[i].src1_val = 64'(cdb_value[c]);
                    end
                    if (!entries[i].src2_rdy && entries[i].src2_tag == cdb_tag[c]) begin
                        entries_next[i].src2_rdy = 1'b1;
                        entries_next[i].src2_val = 64'(cdb_value[c]);
                    end
                end
            end
            if (freed[i]) entries_next[i].valid = 1'b0;
        end
        for (int l = 0; l < FETCH_W; l++) begin
            if (lane_go[l]) begin
                new_ent.valid    = 1'b1;
                new_ent.op       = rs_alloc_op[l];
                new_ent.dst      = rs_alloc_dst_tag[l];
                new_ent.src1_tag = rs_alloc_src1_tag[l];
                new_ent.src2_tag = rs_alloc_src2_tag[l];
                new_ent.src1_rdy = rs_alloc_src1_ready[l];
                new_ent.src2_rdy = rs_alloc_src2_ready[l];
                new_ent.src1_val = rs_alloc_src1_val[l];
                new_ent.src2_val = rs_alloc_src2_val[l];
                new_ent.rob_tag  = rs_alloc_rob_tag[l];
                for (int c = 0; c < 2; c++) begin
                    if (cdb_valid[c] && !rs_alloc_src1_ready[l] && rs_alloc_src1_tag[l] == cdb_tag[c]) begin
                        new_ent.src1_rdy = 1'b1;
                        new_ent.src1_val = 64'(cdb_value[c]);
                    end
                    if (cdb_valid[c] && !rs_alloc_src2_ready[l] && rs_alloc_src2_tag[l] == cdb_tag[c]) begin
                        new_ent.src2_rdy = 1'b1;
                        new_ent.src2_val = 64'(cdb_value[c]);
                    end
                end
                entries_next[lane_slot[l]] = new_ent;
                // New entry is younger than every surviving entry and earlier lanes.
                age_next[lane_slot[l]] = '0;
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (valid_vec[j] && !freed[j]) age_next[j][lane_slot[l]] = 1'b1;
                end
                for (int m = 0; m < l; m++) begin
                    if (lane_go[m]) age_next[lane_slot[m]][lane_slot[l]] = 1'b1;
                end
            end
        end
        if (flush_pipeline) begin
            for (int i = 0; i < RS_ENTRIES; i++) entries_next[i].valid = 1'b0;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            count_next = count_next + CW'(entries_next[i].valid);
        end
        full_next = (count_next > CW'(RS_ENTRIES - FETCH_W));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RS_ENTRIES; i++) entries[i] <= '0;
            age     <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) entries[i] <= entries_next[i];
            age     <= age_next;
            count_q <= count_next;
            full_q  <= full_next;
        end
    end

    alloc_while_full: assert property (@(posedge clk) disable iff (!reset)
        (full_q && !flush_pipeline) |-> (rs_alloc_en == '0));

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for alu_reservation_station: an age-ordered
// queue model predicts every cycle's issue and occupancy; a monitor compares.
module tb_alu_reservation_station;

    localparam int FW = 2;
    localparam int IWD = 2;
    localparam int NE = 16;
    localparam int PW = 6;
    localparam int XL = 64;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush_pipeline;
    logic [FW-1:0]             rs_alloc_en;
    logic [FW-1:0][PW-1:0]     rs_alloc_dst_tag, rs_alloc_src1_tag, rs_alloc_src2_tag;
    logic [FW-1:0][63:0]       rs_alloc_src1_val, rs_alloc_src2_val;
    logic [FW-1:0]             rs_alloc_src1_ready, rs_alloc_src2_ready;
    logic [FW-1:0][7:0]        rs_alloc_op;
    logic [FW-1:0][5:0]        rs_alloc_rob_tag;
    logic                      rs_full;
    logic [4:0]                rs_count;
    logic [1:0]                cdb_valid;
    logic [1:0][PW-1:0]        cdb_tag;
    logic [1:0][XL-1:0]        cdb_value;
    logic [IWD-1:0]            issue_valid, issue_ready;
    logic [IWD-1:0][7:0]       issue_op;
    logic [IWD-1:0][PW-1:0]    issue_dst_tag;
    logic [IWD-1:0][63:0]      issue_src1_val, issue_src2_val;
    logic [IWD-1:0][5:0]       issue_rob_tag;

    alu_reservation_station dut (
        .clk(clk), .reset(reset), .flush_pipeline(flush_pipeline),
        .rs_alloc_en(rs_alloc_en), .rs_alloc_dst_tag(rs_alloc_dst_tag),
        .rs_alloc_src1_tag(rs_alloc_src1_tag), .rs_alloc_src2_tag(rs_alloc_src2_tag),
        .rs_alloc_src1_val(rs_alloc_src1_val), .rs_alloc_src2_val(rs_alloc_src2_val),
        .rs_alloc_src1_ready(rs_alloc_src1_ready), .rs_alloc_src2_ready(rs_alloc_src2_ready),
        .rs_alloc_op(rs_alloc_op), .rs_alloc_rob_tag(rs_alloc_rob_tag),
        .rs_full(rs_full), .rs_count(rs_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_dst_tag(issue_dst_tag), .issue_src1_val(issue_src1_val),
        .issue_src2_val(issue_src2_val), .issue_rob_tag(issue_rob_tag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  op;
        logic [5:0]  dst, t1, t2, rob;
        logic        r1, r2;
        logic [63:0] v1, v2;
    } m_ent_t;

    m_ent_t       mq[$];
    logic [147:0] exp_q[$];
    logic [7:0]   cyc_q[$];
    logic [7:0]   mon_rec;
    logic [147:0] mon_exp, mon_got;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Lane 1 is consulted first so it takes precedence over lane 0.
    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r = e;
        for (int c = 1; c >= 0; c--) begin
            if (cdb_valid[c] && !r.r1 && r.t1 == cdb_tag[c]) begin r.r1 = 1'b1; r.v1 = cdb_value[c]; end
            if (cdb_valid[c] && !r.r2 && r.t2 == cdb_tag[c]) begin r.r2 = 1'b1; r.v2 = cdb_value[c]; end
        end
        return r;
    endfunction

    function automatic m_ent_t mk(input int l);
        m_ent_t e;
        e.op = rs_alloc_op[l];        e.dst = rs_alloc_dst_tag[l];
        e.t1 = rs_alloc_src1_tag[l];  e.t2 = rs_alloc_src2_tag[l];
        e.r1 = rs_alloc_src1_ready[l]; e.r2 = rs_alloc_src2_ready[l];
        e.v1 = rs_alloc_src1_val[l];  e.v2 = rs_alloc_src2_val[l];
        e.rob = rs_alloc_rob_tag[l];
        return wake(e);
    endfunction

    // One cycle of the reference: the queue is held oldest-first.
    task automatic model_eval();
        m_ent_t nq[$];
        int     pick0, pick1, np;
        logic   full_now;
        np = 0; pick0 = -1; pick1 = -1;
        full_now = (mq.size() > NE - FW);
        if (!flush_pipeline) begin
            foreach (mq[i]) begin
                if (mq[i].r1 && mq[i].r2) begin
                    if (np == 0) pick0 = i;
                    else if (np == 1) pick1 = i;
                    np++;
                end
            end
        end
        if (np > 2) np = 2;
        if (pick0 >= 0) exp_q.push_back({mq[pick0].op, mq[pick0].dst, mq[pick0].v1, mq[pick0].v2, mq[pick0].rob});
        if (pick1 >= 0) exp_q.push_back({mq[pick1].op, mq[pick1].dst, mq[pick1].v1, mq[pick1].v2, mq[pick1].rob});
        cyc_q.push_back({np >= 2, np >= 1, full_now, 5'(mq.size())});
        foreach (mq[i]) begin
            if (!((i == pick0 && issue_ready[0]) || (i == pick1 && issue_ready[1])))
                nq.push_back(wake(mq[i]));
        end
        if (flush_pipeline) nq.delete();
        else if (!full_now) begin
            for (int l = 0; l < FW; l++) if (rs_alloc_en[l]) nq.push_back(mk(l));
        end
        mq = nq;
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] rdy);
        rs_alloc_en = '0; cdb_valid = '0; flush_pipeline = 1'b0; issue_ready = rdy;
    endtask

    task automatic lane(input int l, input logic [5:0] rob, input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2);
        rs_alloc_en[l] = 1'b1;          rs_alloc_rob_tag[l] = rob;
        rs_alloc_src1_tag[l] = t1;      rs_alloc_src1_ready[l] = r1;
        rs_alloc_src2_tag[l] = t2;      rs_alloc_src2_ready[l] = r2;
        rs_alloc_src1_val[l] = {$urandom, $urandom};
        rs_alloc_src2_val[l] = {$urandom, $urandom};
        rs_alloc_op[l] = {6'($urandom), 2'b00};
        rs_alloc_dst_tag[l] = 6'($urandom);
    endtask

    task automatic cdb(input int c, input logic [5:0] t, input logic [63:0] v);
        cdb_valid[c] = 1'b1; cdb_tag[c] = t; cdb_value[c] = v;
    endtask

    task automatic drain();
        for (int n = 0; n < 24 && mq.size() != 0; n++) begin idle(2'b11); step(); end
        if (mq.size() != 0) begin idle(2'b00); flush_pipeline = 1'b1; step(); end
        idle(2'b11); step();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() != 0) begin
                mon_rec = cyc_q.pop_front();
                check("rs_count", rs_count, mon_rec[4:0]);
                check("rs_full", rs_full, mon_rec[5]);
                check("issue_valid", issue_valid, mon_rec[7:6]);
                for (int k = 0; k < 2; k++) begin
                    mon_got = {issue_op[k], issue_dst_tag[k], issue_src1_val[k], issue_src2_val[k], issue_rob_tag[k]};
                    mon_exp = mon_rec[6+k] ? exp_q.pop_front() : '0;
                    check($sformatf("issue_payload_p%0d", k), mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle(2'b00);
        rs_alloc_dst_tag = '0; rs_alloc_src1_tag = '0; rs_alloc_src2_tag = '0;
        rs_alloc_src1_val = '0; rs_alloc_src2_val = '0; rs_alloc_src1_ready = '0;
        rs_alloc_src2_ready = '0; rs_alloc_op = '0; rs_alloc_rob_tag = '0;
        cdb_tag = '0; cdb_value = '0;
        // Reset held with random traffic on every input.
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            idle(2'($urandom));
            flush_pipeline = 1'($urandom);
            for (int l = 0; l < FW; l++) lane(l, 6'($urandom), 6'($urandom), 1'($urandom), 6'($urandom), 1'($urandom));
            cdb(0, 6'($urandom), {$urandom, $urandom});
            cdb(1, 6'($urandom), {$urandom, $urandom});
            @(negedge clk);
            check("reset_issue_valid", issue_valid, 2'b00);
            check("reset_rs_count", rs_count, 5'd0);
        end
        @(posedge clk); #1;
        idle(2'b11);
        reset = 1'b1;
        step(); step();

        // Back-to-back pair issues in allocation order.
        lane(0, 6'd3, 6'd0, 1'b1, 6'd0, 1'b1);
        lane(1, 6'd4, 6'd0, 1'b1, 6'd0, 1'b1);
        step(); idle(2'b11); step(); step();

        // CDB lane 1 wakes a waiting source two cycles after allocation.
        lane(0, 6'd5, 6'd5, 1'b0, 6'd0, 1'b1);
        step(); idle(2'b11); step();
        cdb(1, 6'd5, 64'h1234);
        step(); idle(2'b11); step(); step();

        // Age order survives slot reuse: index 1 is recycled for the youngest op.
        lane(0, 6'd10, 6'd0, 1'b1, 6'd10, 1'b0);
        lane(1, 6'd11, 6'd0, 1'b1, 6'd11, 1'b0);
        step(); idle(2'b11);
        lane(0, 6'd12, 6'd0, 1'b1, 6'd10, 1'b0);
        lane(1, 6'd13, 6'd0, 1'b1, 6'd10, 1'b0);
        step(); idle(2'b11);
        cdb(0, 6'd11, 64'hbeef);
        step(); idle(2'b11); step();
        lane(0, 6'd14, 6'd0, 1'b1, 6'd10, 1'b0);
        step(); idle(2'b11);
        cdb(0, 6'd10, 64'h5a5a_0000_1111_2222);
        step(); idle(2'b11); step(); step(); step();
        drain();

        // Fill to 15 under backpressure, hold, accept one, then wake and drain.
        for (int n = 0; n < 8; n++) begin
            idle(2'b00);
            lane(0, 6'(20 + 2*n), 6'd20, (n == 0), 6'd0, 1'b1);
            if (n < 7) lane(1, 6'(21 + 2*n), 6'd20, (n == 0), 6'd0, 1'b1);
            step();
        end
        idle(2'b00); step(); step(); step();
        idle(2'b01); step();
        idle(2'b00); step();
        cdb(0, 6'd20, 64'hcafe);
        step();
        drain();

        // Flush with pending entries and a same-cycle allocation.
        for (int n = 0; n < 3; n++) begin
            idle(2'b00);
            lane(0, 6'(40 + 2*n), 6'd30, (n == 0), 6'd0, 1'b1);
            lane(1, 6'(41 + 2*n), 6'd30, 1'b0, 6'd0, 1'b1);
            step();
        end
        idle(2'b11);
        flush_pipeline = 1'b1;
        lane(0, 6'd50, 6'd0, 1'b1, 6'd0, 1'b1);
        step();
        idle(2'b11);
        cdb(0, 6'd30, 64'h77);
        step(); idle(2'b11); step(); step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            idle(2'($urandom));
            for (int l = 0; l < FW; l++) begin
                if ($urandom_range(0, 2) != 0 && mq.size() <= NE - FW)
                    lane(l, 6'($urandom), 6'($urandom_range(0, 15)), 1'($urandom),
                         6'($urandom_range(0, 15)), 1'($urandom));
            end
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 1) != 0) cdb(c, 6'($urandom_range(0, 15)), {$urandom, $urandom});
            end
            if ($urandom_range(0, 39) == 0) flush_pipeline = 1'b1;
            step();
        end

        // Asynchronous reset in the middle of traffic.
        for (int n = 0; n < 4; n++) begin
            idle(2'b00);
            lane(0, 6'(60 + n), 6'd0, 1'b1, 6'd0, 1'b1);
            step();
        end
        reset = 1'b0;
        @(negedge clk);
        check("midreset_issue_valid", issue_valid, 2'b00);
        check("midreset_rs_count", rs_count, 5'd0);
        check("midreset_rs_full", rs_full, 1'b0);
        @(posedge clk); #1;
        idle(2'b11);
        reset = 1'b1;
        mq.delete();
        step(); step(); step();
        lane(0, 6'd33, 6'd0, 1'b1, 6'd0, 1'b1);
        step(); idle(2'b11); step(); step();

        check("leftover_expected_issues", exp_q.size(), 0);
        check("leftover_cycle_records", cyc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
